// File: rtl/step_motor_sequencer.sv
// Multi-channel stepper motor phase sequencer with per-channel step divider,
// step counter, synchronized driver-fault input and sticky fault flag.
module step_motor_sequencer #(
    parameter int unsigned CH    = 4,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   in_clk,
    input  logic                   MSE_RESETN,
    input  logic [CH-1:0]          start,
    input  logic [CH-1:0]          abort,
    input  logic [CH-1:0]          dir,
    input  logic [2*CH-1:0]        mode,
    input  logic [CH*DIV_W-1:0]    div,
    input  logic [CH*CNT_W-1:0]    steps,
    input  logic [CH-1:0]          fault_n,
    output logic [CH-1:0]          AX,
    output logic [CH-1:0]          AY,
    output logic [CH-1:0]          BX,
    output logic [CH-1:0]          BY,
    output logic [CH-1:0]          busy,
    output logic [CH-1:0]          done,
    output logic [CH-1:0]          faulted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Coil pattern {AX,AY,BX,BY} for each half-step phase index.
    function automatic logic [3:0] phase_pat(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b1000;
            3'd1:    p = 4'b1010;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b0101;
            3'd6:    p = 4'b0001;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_e             st_q, st_d;
        logic [2:0]         idx_q, idx_d;
        logic [DIV_W-1:0]   cnt_q, cnt_d;
        logic [DIV_W-1:0]   div_q, div_d;
        logic [CNT_W-1:0]   rem_q, rem_d;
        logic               dir_q, dir_d;
        logic [1:0]         mode_q, mode_d;
        logic               faulted_q, faulted_d;
        logic               done_q, done_d;
        logic               busy_q, busy_d;
        logic [3:0]         pat_q, pat_d;
        logic [1:0]         sync_q;
        logic [1:0]         mode_in_c;
        logic [DIV_W-1:0]   div_in_c;
        logic [CNT_W-1:0]   steps_in_c;
        logic [2:0]         step_sz_c;

        assign mode_in_c  = mode[2*g +: 2];
        assign div_in_c   = div[g*DIV_W +: DIV_W];
        assign steps_in_c = steps[g*CNT_W +: CNT_W];
        assign step_sz_c  = (mode_q == 2'b10) ? 3'd1 : 3'd2;

        // Event priority: fault, then abort, then start, then divider step.
        always_comb begin
            st_d      = st_q;
            idx_d     = idx_q;
            cnt_d     = cnt_q;
            div_d     = div_q;
            rem_d     = rem_q;
            dir_d     = dir_q;
            mode_d    = mode_q;
            faulted_d = faulted_q;
            done_d    = 1'b0;
            if (!sync_q[1]) begin
                st_d      = ST_FAULT;
                faulted_d = 1'b1;
            end else if (abort[g]) begin
                if (st_q == ST_RUN) st_d = ST_IDLE;
            end else if (start[g] && (st_q != ST_RUN)) begin
                dir_d     = dir[g];
                mode_d    = mode_in_c;
                div_d     = div_in_c;
                cnt_d     = div_in_c;
                rem_d     = steps_in_c;
                faulted_d = 1'b0;
                case (mode_in_c)
                    2'b10:   idx_d = idx_q;
                    2'b00:   idx_d = {idx_q[2:1], 1'b0};
                    default: idx_d = {idx_q[2:1], 1'b1};
                endcase
                if (steps_in_c == '0) begin
                    st_d   = ST_IDLE;
                    done_d = 1'b1;
                end else begin
                    st_d   = ST_RUN;
                end
            end else if (st_q == ST_RUN) begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    idx_d = dir_q ? (idx_q + step_sz_c) : (idx_q - step_sz_c);
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        st_d   = ST_IDLE;
                        done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            busy_d = (st_d == ST_RUN);
            pat_d  = (st_d == ST_FAULT) ? 4'b0000 : phase_pat(idx_d);
        end

        always_ff @(posedge in_clk or negedge MSE_RESETN) begin
            if (!MSE_RESETN) begin
                st_q      <= ST_IDLE;
                idx_q     <= 3'd0;
                cnt_q     <= '0;
                div_q     <= '0;
                rem_q     <= '0;
                dir_q     <= 1'b0;
                mode_q    <= 2'b00;
                faulted_q <= 1'b0;
                done_q    <= 1'b0;
                busy_q    <= 1'b0;
                pat_q     <= 4'b1000;
                sync_q    <= 2'b11;
            end else begin
                st_q      <= st_d;
                idx_q     <= idx_d;
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                rem_q     <= rem_d;
                dir_q     <= dir_d;
                mode_q    <= mode_d;
                faulted_q <= faulted_d;
                done_q    <= done_d;
                busy_q    <= busy_d;
                pat_q     <= pat_d;
                sync_q    <= {sync_q[0], fault_n[g]};
            end
        end

        assign AX[g]      = pat_q[3];
        assign AY[g]      = pat_q[2];
        assign BX[g]      = pat_q[1];
        assign BY[g]      = pat_q[0];
        assign busy[g]    = busy_q;
        assign done[g]    = done_q;
        assign faulted[g] = faulted_q;
    end

endmodule
